// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multicycle load/store sequencer that sits between the core datapath and the
// data port of the unified memory. It takes one request from the control unit
// during the MEM step and always talks to memory with word-aligned full-word
// accesses:
//   - loads read the containing word, then extract and extend the addressed
//     byte or half;
//   - sb/sh read the containing word, merge the new lane into it, and write
//     the merged word back (read-modify-write);
//   - sw writes the word directly with no read;
//   - illegal width codes and misaligned addresses are aborted without any
//     memory access and reported with the misaligned flag.
// A one-cycle done pulse reports completion.
//
// Parameters
//   READ_LATENCY  cycles from the first cycle mem_address is presented until
//                 mem_data_out is valid (legal range 1..4)
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         request strobe; only looked at while idle
//   is_store      1 = store, 0 = load
//   funct3        RV32I load/store width code
//   addr          byte address of the access
//   store_data    store operand (rs2)
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   misaligned    valid with done; the access was aborted
//   load_data     extended load result, held until the next successful load
//   mem_address   word-aligned address to memory, held stable while busy
//   mem_funct3    always a word access (3'b010)
//   mem_wren      memory write enable, high for exactly one cycle per store
//   mem_data_in   write word to memory
//   mem_data_out  read word from memory
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic [2:0]  mem_funct3,
    output logic        mem_wren,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    // Wait-counter preload; the read wait runs from this value down to zero,
    // which gives READ_LATENCY+1 cycles in RD_WAIT.
    localparam logic [2:0] LAT_PRELOAD = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------

    // Pull the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            3'b010:  res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of a memory word with store data.
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = word;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res = word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0] = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [31:0] r_store_data;
    logic [2:0]  r_cnt;

    logic        r_busy;
    logic        r_done;
    logic        r_misaligned;
    logic [31:0] r_load_data;
    logic [31:0] r_mem_address;
    logic        r_mem_wren;
    logic [31:0] r_mem_data_in;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_abort;
    logic        w_is_sw;

    // Classify the incoming request: unsupported width codes and misaligned
    // half/word addresses are aborted before memory is touched.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (is_store) begin
            w_illegal = (funct3 > 3'b010);
        end else begin
            w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                        (funct3 == 3'b111);
        end
        if (funct3[1:0] == 2'b01) begin
            w_misalign = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            w_misalign = (addr[1:0] != 2'b00);
        end else begin
            w_misalign = 1'b0;
        end
        w_abort = w_illegal || w_misalign;
        w_is_sw = is_store && (funct3 == 3'b010);
    end

    // Sequencer FSM; every output is a register updated on the transition
    // into the state that owns it, so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_lane        <= 2'd0;
            r_funct3      <= 3'd0;
            r_is_store    <= 1'b0;
            r_store_data  <= 32'h0000_0000;
            r_cnt         <= 3'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_misaligned  <= 1'b0;
            r_load_data   <= 32'h0000_0000;
            r_mem_address <= 32'h0000_0000;
            r_mem_wren    <= 1'b0;
            r_mem_data_in <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_mem_wren   <= 1'b0;
                    if (start) begin
                        r_lane        <= addr[1:0];
                        r_funct3      <= funct3;
                        r_is_store    <= is_store;
                        r_store_data  <= store_data;
                        r_mem_address <= {addr[31:2], 2'b00};
                        r_busy        <= 1'b1;
                        if (w_abort) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else if (w_is_sw) begin
                            // Full-word store needs no read of the old word.
                            r_state       <= WRITE;
                            r_mem_wren    <= 1'b1;
                            r_mem_data_in <= store_data;
                        end else begin
                            r_state <= RD_WAIT;
                            r_cnt   <= LAT_PRELOAD;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                RD_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        // Read word is valid now: finish the load, or build
                        // the merged word for the write-back. mem_data_in
                        // doubles as the captured-word register.
                        if (r_is_store) begin
                            r_state       <= WRITE;
                            r_mem_wren    <= 1'b1;
                            r_mem_data_in <= merge_store(mem_data_out,
                                                         r_store_data,
                                                         r_funct3, r_lane);
                        end else begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_load_data <= extend_load(mem_data_out,
                                                       r_funct3, r_lane);
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                WRITE: begin
                    r_mem_wren <= 1'b0;
                    r_state    <= DONE;
                    r_done     <= 1'b1;
                end

                DONE: begin
                    // A start seen here is deliberately dropped.
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end

                default: begin
                    r_state      <= IDLE;
                    r_done       <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_busy       <= 1'b0;
                    r_mem_wren   <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign misaligned  = r_misaligned;
    assign load_data   = r_load_data;
    assign mem_address = r_mem_address;
    assign mem_funct3  = 3'b010;
    assign mem_wren    = r_mem_wren;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multicycle load/store sequencer between the core datapath and the unified memory block's data port. It accepts one access request from the control unit during the MEM step. It always drives memory with word-aligned word accesses. Byte/half lane extraction and sign/zero extension happen here for loads. Sub-word stores are done as read-modify-write. It raises a one-cycle done pulse, plus a misalignment flag, back to the control unit.

Parameters:
READ_LATENCY, 1, cycles from the first cycle mem_address is presented until mem_data_out is valid (legal 1..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request strobe from control unit; sampled only in IDLE
is_store  input  1  1 = store, 0 = load
funct3  input  3  RV32I load/store width code
addr  input  32  byte address (ALU output register)
store_data  input  32  rs2 value (reg_b)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
misaligned  output  1  valid with done; access aborted
load_data  output  32  extended load result, registered
mem_address  output  32  word-aligned address to memory
mem_funct3  output  3  constant 3'b010 (word access)
mem_wren  output  1  memory write enable
mem_data_in  output  32  write word to memory
mem_data_out  input  32  read word from memory

Behaviour:
- One clock (clk); reset synchronous, active-high.
- Reset values: busy, done, misaligned, mem_wren = 0; load_data, mem_address, mem_data_in = 0; FSM in IDLE.
- Reset mid-operation: FSM returns to IDLE next edge and mem_wren is 0 from then on. Any pending write is dropped.
- Reset has priority over start.
- States: IDLE, RD_WAIT, WRITE, DONE.
- IDLE:
  - On start, latch addr, funct3, is_store and store_data (cycle 0).
  - Illegal or misaligned request → DONE with misaligned set. Illegal/misaligned means any of:
    - load funct3 in {011, 110, 111};
    - store funct3 above 010;
    - half access with addr[0]=1;
    - word access with addr[1:0]≠0.
  - sw → WRITE.
  - All loads and sb/sh → RD_WAIT with wait counter = READ_LATENCY.
- mem_address = {latched_addr[31:2], 2'b00}, driven from cycle 1. It is held stable while busy.
- RD_WAIT:
  - Lasts READ_LATENCY+1 cycles.
  - On its last cycle, capture mem_data_out into an internal word register.
  - Load → DONE. sb/sh → WRITE.
- WRITE:
  - mem_wren=1 for exactly this one cycle.
  - sw: mem_data_in = store_data.
  - sb: captured word with byte lane addr[1:0] replaced by store_data[7:0].
  - sh: captured word with half lane addr[1] replaced by store_data[15:0].
  - Next state: DONE.
- DONE:
  - done=1 for one cycle; misaligned reflects the abort decision.
  - Next state: IDLE.
  - busy is still 1 in DONE and drops in IDLE.
- Load extension, written to load_data on entry to DONE:
  - lb (000): byte at lane addr[1:0], sign-extended.
  - lbu (100): same byte, zero-extended.
  - lh (001): half at lane addr[1], sign-extended.
  - lhu (101): same half, zero-extended.
  - lw (010): full word.
- load_data holds its value until the next successful load. Stores and aborted accesses leave it unchanged.
- Latency (cycle 0 = start sampled, L = READ_LATENCY):
  - load: done in cycle 2+L;
  - sw: done in cycle 2;
  - sb/sh: wren in cycle 2+L, done in cycle 3+L;
  - abort: done in cycle 1 with no memory access.
- Requests while busy:
  - start while busy is ignored and never queued.
  - A start in the same cycle as DONE is also ignored; a new request is accepted only in IDLE.
- mem_data_in is don't-care when mem_wren=0. It holds its last value.

Test Plan:
- lw addr 0x100, word 0x8899AABB, L=1 → done in cycle 3, load_data=0x8899AABB, mem_address=0x100, mem_wren never 1.
- Extension, same word:
  - lb @0x103 → 0xFFFFFF88;
  - lbu @0x103 → 0x00000088;
  - lh @0x102 → 0xFFFF8899;
  - lhu @0x100 → 0x0000AABB;
  - each has misaligned=0.
- sb @0x101, store_data 0x000000CC, word 0x11223344 → single mem_wren in cycle 3 with mem_address 0x100 and mem_data_in 0x1122CC44; done in cycle 4.
- sw @0x104, store_data 0xDEADBEEF → mem_wren only in cycle 1 with mem_data_in 0xDEADBEEF; done in cycle 2; no read wait.
- Aborts: lw @0x102, sh @0x103, load funct3=011 → each gives done+misaligned in cycle 1, no mem_wren, load_data unchanged.
- Reset and overlapping starts:
  - Reset asserted in cycle 2 of an sb → mem_wren never asserted, busy=0 next cycle, a following lw completes normally.
  - start pulses during busy → no extra done pulses.
